ram_port: RTL and testbench

- Memory-side stage directly downstream of the cpu RAM port (we/addr/wdata out, rdata in).
- Holds a word-organised on-chip data/instruction store.
- Services one request at a time through a req/ready handshake, with a programmable number of wait states.
- Lets fetch and control stall on slow memory instead of assuming single-cycle RAM.

---
 rtl/ram_port.sv | 86 ++++++++
 tb/tb_ram_port.sv | 117 +++++++++++
 2 files changed

// File: rtl/ram_port.sv
// ram_port: word-organised store behind a req/ready handshake with WAIT_CYCLES wait states.
// Define RAM_PORT_FAULT_EN to fault out-of-range accesses instead of wrapping the index.
module ram_port #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  be_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        fault_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [3:0]    cnt;
  logic          we_q, oor_q, oor_i, idle, commit;
  logic [AW-1:0] idx_q;
  logic [31:0]   data_q;
  logic [3:0]    be_q;
  logic          c_we, c_oor;
  logic [AW-1:0] c_idx;
  logic [31:0]   c_data;
  logic [3:0]    c_be;
  logic [31:0]   mem [DEPTH];
  logic          unused;
  assign unused = ^{addr_i[31:AW+2], addr_i[1:0]};
`ifdef RAM_PORT_FAULT_EN
  assign oor_i = |addr_i[31:AW+2];
`else
  assign oor_i = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= nxt;
  always_comb
    nxt = state == IDLE ? (req_i ? (WAIT_CYCLES == 0 ? DONE : WAIT) : IDLE) :
          state == WAIT ? (cnt == 4'd1 ? DONE : WAIT) : IDLE;
  // With zero wait states the commit happens on the accepting edge, so it uses the live inputs
  assign idle   = state == IDLE;
  assign c_we   = idle ? we_i : we_q;
  assign c_oor  = idle ? oor_i : oor_q;
  assign c_idx  = idle ? addr_i[AW+1:2] : idx_q;
  assign c_data = idle ? data_i : data_q;
  assign c_be   = idle ? be_i : be_q;
  assign commit = reset && state != DONE && nxt == DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt    <= '0;
      we_q   <= 1'b0;
      oor_q  <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
      be_q   <= '0;
      data_o <= '0;
    end else begin
      if (idle && req_i) begin
        cnt    <= 4'(WAIT_CYCLES);
        we_q   <= we_i;
        oor_q  <= oor_i;
        idx_q  <= addr_i[AW+1:2];
        data_q <= data_i;
        be_q   <= be_i;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (commit && !c_we) data_o <= c_oor ? 32'hDEADBEEF : mem[c_idx];
    end
  always_ff @(posedge clk)
    if (commit && c_we && !c_oor)
      for (int b = 0; b < 4; b++)
        if (c_be[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
`ifdef RAM_PORT_FAULT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) fault_o <= 1'b0;
    else        fault_o <= commit && c_oor;
`else
  assign fault_o = 1'b0;
`endif
  assign ready_o = state == DONE;
  assign busy_o  = state != IDLE;
endmodule

// File: tb/tb_ram_port.sv
// tb_ram_port: scoreboard bench for ram_port; a WAIT_CYCLES=2 instance for most vectors, a zero-wait one for throughput.
module tb_ram_port;
  localparam int W = 2;
  logic        clk = 0, reset = 1, req_a = 0, req_b = 0, we_i = 0;
  logic [31:0] addr_i = 0, data_i = 0;
  logic [3:0]  be_i = 0;
  logic [31:0] data_a, data_b;
  logic        ready_a, busy_a, fault_a, ready_b, busy_b, fault_b;
  int          cyc = 0, pass_n = 0, tot_n = 0;
  logic        prev_rdy = 0;
  typedef struct {logic [31:0] data; logic fault; bit chk_d; int acc;} exp_t;
  exp_t q[$];

  ram_port #(.DEPTH(1024), .WAIT_CYCLES(W)) dut_a (
    .clk(clk), .reset(reset), .req_i(req_a), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .be_i(be_i), .data_o(data_a), .ready_o(ready_a), .busy_o(busy_a), .fault_o(fault_a));
  ram_port #(.DEPTH(1024), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_i(req_b), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .be_i(be_i), .data_o(data_b), .ready_o(ready_b), .busy_o(busy_b), .fault_o(fault_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  always @(negedge clk) begin
    if (reset && ready_a) begin
      chk("ready_one_cycle", {31'b0, prev_rdy}, 32'd0);
      if (q.size() == 0) begin
        tot_n++;
        $display("FAIL unexpected_ready: got ready_o=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk_d) chk("rdata", data_a, e.data);
        chk("fault", {31'b0, fault_a}, {31'b0, e.fault});
        chk("latency", cyc - e.acc, W + 1);
      end
    end
    prev_rdy = ready_a;
  end

  // Called at a negedge with dut_a idle; returns at a negedge with dut_a idle again
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic [31:0] exp_d, input logic exp_f,
                        input bit chk_d, input bit abort);
    int n;
    we_i = we; addr_i = addr; data_i = data; be_i = be; req_a = 1;
    if (!abort) q.push_back('{exp_d, exp_f, chk_d, cyc});
    @(posedge clk);
    #1 req_a = 0; addr_i = 32'h14; data_i = 32'hFFFFFFFF; we_i = !we; be_i = ~be;
    if (abort) begin
      @(negedge clk);
      #2 reset = 0;
      #1 chk("abort_busy", {31'b0, busy_a}, 32'd0);
      chk("abort_ready", {31'b0, ready_a}, 32'd0);
      chk("abort_data", data_a, 32'd0);
      @(negedge clk) reset = 1;
      @(negedge clk);
      return;
    end
    n = 0;
    @(negedge clk);
    while (busy_a && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, W + 1);
  endtask

  initial begin
    int mask;
    #13 reset = 0;
    #1 chk("rst_ready", {31'b0, ready_a}, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_fault", {31'b0, fault_a}, 32'd0);
    chk("rst_data", data_a, 32'd0);
    @(negedge clk) reset = 1;
    @(negedge clk);
    access(1, 32'h0,  32'h01234567, 4'hF, 32'h0,        0, 1, 0);
    access(0, 32'h0,  32'h0,        4'h0, 32'h01234567, 0, 1, 0);
    access(1, 32'h40, 32'h11223344, 4'hF, 32'h01234567, 0, 1, 0);
    access(1, 32'h40, 32'hAABBCCDD, 4'h5, 32'h01234567, 0, 1, 0);
    access(1, 32'h40, 32'hFFFFFFFF, 4'h0, 32'h01234567, 0, 1, 0);
    access(0, 32'h43, 32'h0,        4'hF, 32'h11BB33DD, 0, 1, 0);
    access(1, 32'h8,  32'h55AA55AA, 4'hF, 32'h11BB33DD, 0, 1, 0);
    access(1, 32'h8,  32'hCAFEF00D, 4'hF, 32'h0,        0, 0, 1);
    access(0, 32'h8,  32'h0,        4'h0, 32'h55AA55AA, 0, 1, 0);
    access(1, 32'h14, 32'h0BADF00D, 4'hF, 32'h55AA55AA, 0, 1, 0);
    access(1, 32'h10, 32'h12345678, 4'hF, 32'h55AA55AA, 0, 1, 0);
    access(0, 32'h10, 32'h0,        4'h0, 32'h12345678, 0, 1, 0);
    access(0, 32'h14, 32'h0,        4'h0, 32'h0BADF00D, 0, 1, 0);
`ifdef RAM_PORT_FAULT_EN
    access(0, 32'h1000, 32'h0, 4'h0, 32'hDEADBEEF, 1, 1, 0);
`else
    access(0, 32'h1000, 32'h0, 4'h0, 32'h01234567, 0, 1, 0);
`endif
    we_i = 0; addr_i = 0; data_i = 0; be_i = 0; req_b = 1;
    mask = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_b) mask |= 1 << i;
    end
    req_b = 0;
    chk("zero_wait_pulses", $countones(mask), 32'd3);
    chk("zero_wait_pattern", mask, 32'b010101);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
